// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: sphere-tracing sequencer for one ray.
// Computes p = origin + dir*t, issues one scene-distance query per step and
// accumulates t until hit, far-plane miss or step exhaustion. All values are
// signed Q8.24; vec3 is packed {x,y,z}.
// Optional feature macro: RM_TIMEOUT_EN (query watchdog of TIMEOUT_CYC cycles).
module ray_march_ctrl #(
    parameter int          MAX_STEPS = 64,
    parameter logic [31:0] HIT_EPS   = 32'h00004189,
    parameter logic [31:0] MAX_T     = 32'h0A000000
`ifdef RM_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [95:0] ray_origin,
    input  logic [95:0] ray_dir,
    input  logic        obj_sel_in,
    output logic        q_valid_in,
    output logic [95:0] q_pos,
    output logic        q_obj_sel,
    input  logic [31:0] q_dist,
    input  logic        q_valid_out,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [31:0] t_out,
    output logic [7:0]  steps_out,
    output logic        timeout
);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, UPDATE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [95:0] origin_reg, dir_reg, q_pos_reg;
    logic [31:0] t_reg, dist_reg, t_out_reg;
    logic [7:0]  steps_reg, steps_out_reg;
    logic        q_obj_sel_reg, busy_reg, done_reg, hit_reg, hit_res_reg;
    logic [95:0] pos_calc;
    logic [31:0] t_sum, t_sat;
    logic        dist_hit;

    // Per-axis sample position: o + (d*t)[55:24], truncated product.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic signed [63:0] prod;
            logic               unused_prod_bits;
            assign prod = $signed(dir_reg[gi*32 +: 32]) * $signed(t_reg);
            assign pos_calc[gi*32 +: 32] = origin_reg[gi*32 +: 32] + prod[55:24];
            assign unused_prod_bits = ^{prod[63:56], prod[23:0]};
        end
    endgenerate

    // t never goes negative and dist is positive on the non-hit path, so a
    // set sign bit on the sum means it overflowed past the largest fp value.
    assign dist_hit = $signed(dist_reg) < $signed(HIT_EPS);
    assign t_sum    = t_reg + dist_reg;
    assign t_sat    = t_sum[31] ? 32'h7FFFFFFF : t_sum;

`ifdef RM_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    logic [WCW-1:0] wait_cnt_reg;
    logic           to_res_reg, timeout_reg;
    logic           wait_expired;
    assign wait_expired = (wait_cnt_reg == WCW'(TIMEOUT_CYC - 1));
    assign timeout      = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    // Next-state decode and the single-cycle query strobe.
    always_comb begin
        state_next = state_reg;
        q_valid_in = 1'b0;
        case (state_reg)
            IDLE:   if (start) state_next = CALC;
            CALC:   state_next = ISSUE;
            ISSUE: begin
                q_valid_in = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (q_valid_out) state_next = UPDATE;
`ifdef RM_TIMEOUT_EN
                else if (wait_expired) state_next = DONE;
`endif
            end
            UPDATE: begin
                if (dist_hit)                         state_next = DONE;
                else if (t_sat > MAX_T)               state_next = DONE;
                else if (steps_reg == 8'(MAX_STEPS))  state_next = DONE;
                else                                  state_next = CALC;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath; results are published together with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            origin_reg    <= '0;
            dir_reg       <= '0;
            q_pos_reg     <= '0;
            t_reg         <= '0;
            dist_reg      <= '0;
            t_out_reg     <= '0;
            steps_reg     <= '0;
            steps_out_reg <= '0;
            q_obj_sel_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            hit_res_reg   <= 1'b0;
`ifdef RM_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            to_res_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    origin_reg    <= ray_origin;
                    dir_reg       <= ray_dir;
                    q_obj_sel_reg <= obj_sel_in;
                    t_reg         <= '0;
                    steps_reg     <= '0;
                    hit_res_reg   <= 1'b0;
                    busy_reg      <= 1'b1;
`ifdef RM_TIMEOUT_EN
                    to_res_reg    <= 1'b0;
`endif
                end
                CALC: q_pos_reg <= pos_calc;
                ISSUE: begin
                    steps_reg <= steps_reg + 8'd1;
`ifdef RM_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (q_valid_out) dist_reg <= q_dist;
`ifdef RM_TIMEOUT_EN
                    else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        if (wait_expired) begin
                            to_res_reg  <= 1'b1;
                            hit_res_reg <= 1'b0;
                        end
                    end
`endif
                end
                UPDATE: begin
                    if (dist_hit) begin
                        hit_res_reg <= 1'b1;
                    end else begin
                        hit_res_reg <= 1'b0;
                        t_reg       <= t_sat;
                    end
                end
                DONE: begin
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    hit_reg       <= hit_res_reg;
                    t_out_reg     <= t_reg;
                    steps_out_reg <= steps_reg;
`ifdef RM_TIMEOUT_EN
                    timeout_reg   <= to_res_reg;
`endif
                end
                default: ;
            endcase
        end
    end

    assign q_pos     = q_pos_reg;
    assign q_obj_sel = q_obj_sel_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign hit       = hit_reg;
    assign t_out     = t_out_reg;
    assign steps_out = steps_out_reg;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Directed testbench for ray_march_ctrl (MAX_STEPS=4 so exhaustion is reachable).
// The scene query is a stub that answers 3 cycles after each strobe.
module tb_ray_march_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [95:0] ray_origin = '0;
    logic [95:0] ray_dir = '0;
    logic        obj_sel_in = 1'b0;
    logic        q_valid_in;
    logic [95:0] q_pos;
    logic        q_obj_sel;
    logic [31:0] q_dist = '0;
    logic        q_valid_out = 1'b0;
    logic        busy, done, hit, timeout;
    logic [31:0] t_out;
    logic [7:0]  steps_out;

    int checks = 0;
    int failures = 0;

    int          strobe_cyc, n_strobes, n_done;
    bit          got_done;
    logic [95:0] first_pos, last_pos;

    localparam logic [95:0] ORG_Z = {32'h0, 32'h0, 32'hFF000000};
    localparam logic [95:0] DIR_Z = {32'h0, 32'h0, 32'h01000000};

    ray_march_ctrl #(
        .MAX_STEPS(4)
`ifdef RM_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel_in(obj_sel_in),
        .q_valid_in(q_valid_in), .q_pos(q_pos), .q_obj_sel(q_obj_sel),
        .q_dist(q_dist), .q_valid_out(q_valid_out),
        .busy(busy), .done(done), .hit(hit), .t_out(t_out),
        .steps_out(steps_out), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Launch one ray and run the stub until done (bounded). The first reply
    // is d_first, later replies d_rest. Everything happens on negedges.
    task automatic run_ray(input logic [95:0] o, input logic [95:0] d, input logic sel,
                           input logic [31:0] d_first, input logic [31:0] d_rest,
                           input bit hold_start, input bit spurious);
        int  cyc;
        int  pend;
        bit  first;
        @(negedge clk);
        ray_origin = o; ray_dir = d; obj_sel_in = sel; start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        cyc = 1; pend = -1; first = 1'b1;
        got_done = 1'b0; strobe_cyc = -1; n_strobes = 0; n_done = 0;
        while (!got_done && cyc < 400) begin
            q_valid_out = 1'b0;
            if (pend > 0) pend--;
            else if (pend == 0) begin
                q_valid_out = 1'b1;
                q_dist = first ? d_first : d_rest;
                first = 1'b0;
                pend = -1;
            end
            if (spurious && cyc == 1) begin
                q_valid_out = 1'b1;
                q_dist = 32'h0;
            end
            if (q_valid_in) begin
                n_strobes++;
                if (strobe_cyc < 0) begin
                    strobe_cyc = cyc;
                    first_pos = q_pos;
                end
                last_pos = q_pos;
                pend = 2;
            end
            if (done) begin
                got_done = 1'b1;
                n_done++;
                start = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        q_valid_out = 1'b0;
        start = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL ray_timeout: done=0 after %0d cycles, required done=1", cyc);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, hit, timeout, q_valid_in, q_obj_sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000",
                     {busy, done, hit, timeout, q_valid_in, q_obj_sel});
        end
        checks++;
        if (q_pos !== 96'h0) begin
            failures++; $display("FAIL reset_q_pos: got %h required 0", q_pos);
        end
        checks++;
        if (t_out !== 32'h0 || steps_out !== 8'h0) begin
            failures++;
            $display("FAIL reset_results: t_out=%h steps_out=%0d required 0/0", t_out, steps_out);
        end
        rst_n = 1'b1;
        $display("reset: flags=%b q_pos=%h t_out=%h", {busy, done, hit}, q_pos, t_out);
    endtask

    task automatic test_sphere_hit;
        run_ray(ORG_Z, DIR_Z, 1'b1, 32'h00E66666, 32'h00000000, 1'b0, 1'b0);
        checks++;
        if (hit !== 1'b1) begin failures++; $display("FAIL hit_flag: got %b required 1", hit); end
        checks++;
        if (t_out !== 32'h00E66666) begin
            failures++; $display("FAIL hit_t_out: got %h required 00e66666", t_out);
        end
        checks++;
        if (steps_out !== 8'd2) begin
            failures++; $display("FAIL hit_steps: got %0d required 2", steps_out);
        end
        checks++;
        if (strobe_cyc !== 2) begin
            failures++; $display("FAIL first_strobe_latency: got %0d required 2", strobe_cyc);
        end
        checks++;
        if (first_pos !== ORG_Z) begin
            failures++; $display("FAIL first_q_pos: got %h required %h", first_pos, ORG_Z);
        end
        checks++;
        if (last_pos !== {32'h0, 32'h0, 32'hFFE66666}) begin
            failures++; $display("FAIL second_q_pos: got %h required z=ffe66666", last_pos);
        end
        checks++;
        if (q_obj_sel !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hit_sel_busy: q_obj_sel=%b busy=%b required 1/0", q_obj_sel, busy);
        end
        $display("sphere_hit: hit=%b t_out=%h steps=%0d strobe_cyc=%0d", hit, t_out, steps_out, strobe_cyc);
    endtask

    task automatic test_far_miss;
        run_ray(ORG_Z, DIR_Z, 1'b0, 32'h03000000, 32'h03000000, 1'b0, 1'b0);
        checks++;
        if (hit !== 1'b0 || timeout !== 1'b0) begin
            failures++; $display("FAIL far_flags: hit=%b timeout=%b required 0/0", hit, timeout);
        end
        checks++;
        if (t_out !== 32'h0C000000) begin
            failures++; $display("FAIL far_t_out: got %h required 0c000000", t_out);
        end
        checks++;
        if (steps_out !== 8'd4 || n_strobes !== 4) begin
            failures++;
            $display("FAIL far_steps: steps_out=%0d strobes=%0d required 4/4", steps_out, n_strobes);
        end
        $display("far_miss: hit=%b t_out=%h steps=%0d", hit, t_out, steps_out);
    endtask

    task automatic test_step_exhaust;
        run_ray(ORG_Z, DIR_Z, 1'b0, 32'h0028F5C2, 32'h0028F5C2, 1'b0, 1'b0);
        checks++;
        if (hit !== 1'b0) begin failures++; $display("FAIL exhaust_hit: got %b required 0", hit); end
        checks++;
        if (t_out !== 32'h00A3D708) begin
            failures++; $display("FAIL exhaust_t_out: got %h required 00a3d708", t_out);
        end
        checks++;
        if (steps_out !== 8'd4 || n_strobes !== 4) begin
            failures++;
            $display("FAIL exhaust_steps: steps_out=%0d strobes=%0d required 4/4", steps_out, n_strobes);
        end
        $display("step_exhaust: hit=%b t_out=%h steps=%0d", hit, t_out, steps_out);
    endtask

    task automatic test_negative_dist;
        run_ray(ORG_Z, DIR_Z, 1'b0, 32'hFF000000, 32'h03000000, 1'b0, 1'b0);
        checks++;
        if (hit !== 1'b1) begin failures++; $display("FAIL neg_hit: got %b required 1", hit); end
        checks++;
        if (t_out !== 32'h0) begin failures++; $display("FAIL neg_t_out: got %h required 0", t_out); end
        checks++;
        if (steps_out !== 8'd1) begin
            failures++; $display("FAIL neg_steps: got %0d required 1", steps_out);
        end
        $display("negative_dist: hit=%b t_out=%h steps=%0d", hit, t_out, steps_out);
    endtask

    task automatic test_start_held;
        run_ray(ORG_Z, DIR_Z, 1'b0, 32'h03000000, 32'h03000000, 1'b1, 1'b0);
        checks++;
        if (n_strobes !== 4 || t_out !== 32'h0C000000) begin
            failures++;
            $display("FAIL held_start_ray: strobes=%0d t_out=%h required 4/0c000000", n_strobes, t_out);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL held_start_second_ray: busy=%b done=%b required 0/0", busy, done);
        end
        $display("start_held: strobes=%0d t_out=%h busy_after=%b", n_strobes, t_out, busy);
    endtask

    task automatic test_spurious_response;
        run_ray(ORG_Z, DIR_Z, 1'b0, 32'h03000000, 32'h03000000, 1'b0, 1'b1);
        checks++;
        if (hit !== 1'b0 || steps_out !== 8'd4 || t_out !== 32'h0C000000) begin
            failures++;
            $display("FAIL spurious_calc: hit=%b steps=%0d t_out=%h required 0/4/0c000000",
                     hit, steps_out, t_out);
        end
        $display("spurious_response: hit=%b steps=%0d t_out=%h", hit, steps_out, t_out);
    endtask

    task automatic test_reset_mid_ray;
        int  k;
        bit  saw_done;
        @(negedge clk);
        ray_origin = ORG_Z; ray_dir = DIR_Z; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!q_valid_in && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, hit} !== 3'b0 || q_pos !== 96'h0 || t_out !== 32'h0 || steps_out !== 8'h0) begin
            failures++;
            $display("FAIL midray_reset_outputs: busy=%b done=%b hit=%b q_pos=%h t_out=%h steps=%0d required all 0",
                     busy, done, hit, q_pos, t_out, steps_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        q_valid_out = 1'b1; q_dist = 32'h0;
        @(negedge clk);
        q_valid_out = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy || q_valid_in) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done) begin
            failures++; $display("FAIL midray_late_response: activity=1 required 0");
        end
        $display("reset_mid_ray: busy=%b done=%b activity=%b", busy, done, saw_done);
    endtask

`ifdef RM_TIMEOUT_EN
    // Strobe, 16 WAIT cycles, one DONE cycle, then registered done: +18.
    task automatic test_timeout;
        int k, s;
        @(negedge clk);
        ray_origin = ORG_Z; ray_dir = DIR_Z; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!q_valid_in && k < 20) begin @(negedge clk); k++; end
        s = k;
        while (!done && k < 200) begin @(negedge clk); k++; end
        checks++;
        if (k - s !== 18) begin
            failures++; $display("FAIL timeout_latency: got %0d required 18", k - s);
        end
        checks++;
        if (timeout !== 1'b1 || hit !== 1'b0 || t_out !== 32'h0 || steps_out !== 8'd1) begin
            failures++;
            $display("FAIL timeout_result: timeout=%b hit=%b t_out=%h steps=%0d required 1/0/0/1",
                     timeout, hit, t_out, steps_out);
        end
        $display("timeout: latency=%0d timeout=%b hit=%b", k - s, timeout, hit);
    endtask
`endif

    initial begin
        test_reset;
        test_sphere_hit;
        test_far_miss;
        test_step_exhaust;
        test_negative_dist;
        test_start_held;
        test_spurious_response;
        test_reset_mid_ray;
`ifdef RM_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
